bram_op_scheduler: RTL

BRAM_OP_SCHEDULER -- requirements
Module: bram_op_scheduler

---
 rtl/bram_op_scheduler.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/bram_op_scheduler.sv
// Read/write op scheduler in front of a BRAM FIFO controller: one op in flight, round-robin
// when both clients are eligible. Optional WAIT watchdog compiled in with BRAM_SCHED_WATCHDOG_EN.
module bram_op_scheduler #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int TO_BITS        = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic clk_en,
  input  logic rd_req,
  input  logic wr_req,
  input  logic is_empty,
  input  logic is_full,
  input  logic rd_done,
  input  logic rd_rdy,
  input  logic wr_done,
  input  logic wr_rdy,
  output logic rd_trigger,
  output logic wr_trigger,
  output logic rd_ack,
  output logic wr_ack,
  output logic rd_client_rdy,
  output logic wr_client_rdy,
  output logic busy,
  output logic timeout_err
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_ISSUE = 3'd1,
    RD_WAIT  = 3'd2,
    WR_ISSUE = 3'd3,
    WR_WAIT  = 3'd4
  } state_t;

  state_t state_reg;
  logic   rd_pend_reg;
  logic   wr_pend_reg;
  logic   last_wr_reg;   // 1: the last completed grant was the write client
  logic   rd_ack_reg;
  logic   wr_ack_reg;
  logic   rd_elig;
  logic   wr_elig;

  assign rd_elig = rd_pend_reg & ~is_empty & rd_rdy;
  assign wr_elig = wr_pend_reg & ~is_full & wr_rdy;

`ifdef BRAM_SCHED_WATCHDOG_EN
  localparam logic [TO_BITS-1:0] WD_LAST = TO_BITS'(TIMEOUT_CYCLES - 1);
  logic [TO_BITS-1:0] wd_cnt_reg;
  logic               timeout_reg;
  logic               wd_expired;

  // Counter holds the number of WAIT cycles already spent without done.
  assign wd_expired  = (wd_cnt_reg == WD_LAST);
  assign timeout_err = timeout_reg;
`else
  localparam int unused_cfg = TIMEOUT_CYCLES + TO_BITS;
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg   <= IDLE;
      rd_pend_reg <= 1'b0;
      wr_pend_reg <= 1'b0;
      last_wr_reg <= 1'b0;
      rd_ack_reg  <= 1'b0;
      wr_ack_reg  <= 1'b0;
`ifdef BRAM_SCHED_WATCHDOG_EN
      wd_cnt_reg  <= '0;
      timeout_reg <= 1'b0;
`endif
    end else if (clk_en) begin
      rd_ack_reg <= 1'b0;
      wr_ack_reg <= 1'b0;
      // Completion clears below take priority over a request seen while still pending.
      if (rd_req) rd_pend_reg <= 1'b1;
      if (wr_req) wr_pend_reg <= 1'b1;

      case (state_reg)
        IDLE: begin
          if (rd_elig && wr_elig) state_reg <= last_wr_reg ? RD_ISSUE : WR_ISSUE;
          else if (rd_elig)       state_reg <= RD_ISSUE;
          else if (wr_elig)       state_reg <= WR_ISSUE;
        end
        RD_ISSUE: begin
          state_reg <= RD_WAIT;
`ifdef BRAM_SCHED_WATCHDOG_EN
          wd_cnt_reg <= '0;
`endif
        end
        RD_WAIT: begin
          if (rd_done) begin
            rd_ack_reg  <= 1'b1;
            rd_pend_reg <= 1'b0;
            last_wr_reg <= 1'b0;
            state_reg   <= IDLE;
          end
`ifdef BRAM_SCHED_WATCHDOG_EN
          else if (wd_expired) begin
            timeout_reg <= 1'b1;
            rd_pend_reg <= 1'b0;
            last_wr_reg <= 1'b0;
            state_reg   <= IDLE;
          end else begin
            wd_cnt_reg <= wd_cnt_reg + 1'b1;
          end
`endif
        end
        WR_ISSUE: begin
          state_reg <= WR_WAIT;
`ifdef BRAM_SCHED_WATCHDOG_EN
          wd_cnt_reg <= '0;
`endif
        end
        WR_WAIT: begin
          if (wr_done) begin
            wr_ack_reg  <= 1'b1;
            wr_pend_reg <= 1'b0;
            last_wr_reg <= 1'b1;
            state_reg   <= IDLE;
          end
`ifdef BRAM_SCHED_WATCHDOG_EN
          else if (wd_expired) begin
            timeout_reg <= 1'b1;
            wr_pend_reg <= 1'b0;
            last_wr_reg <= 1'b1;
            state_reg   <= IDLE;
          end else begin
            wd_cnt_reg <= wd_cnt_reg + 1'b1;
          end
`endif
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Pulses are gated so a stalled clock enable never presents a trigger or ack.
  assign rd_trigger    = clk_en & (state_reg == RD_ISSUE);
  assign wr_trigger    = clk_en & (state_reg == WR_ISSUE);
  assign rd_ack        = clk_en & rd_ack_reg;
  assign wr_ack        = clk_en & wr_ack_reg;
  assign rd_client_rdy = ~rd_pend_reg;
  assign wr_client_rdy = ~wr_pend_reg;
  assign busy          = (state_reg != IDLE);

endmodule
